// File: rtl/paddle_ctrl.sv
// paddle_ctrl -- player paddle controller for the Pong datapath.
//
// Two raw push-buttons are synchronized and debounced. Their state requests
// left, right or no motion. On each animation strobe, the paddle's left edge
// moves by the current speed, and the result is clamped to the legal range.
// Speed starts at 1 px/frame and rises after RAMP_FRAMES moves at one speed,
// up to MAX_SPEED. Reversing direction or releasing the buttons drops the
// speed back to 1.
//
// Ports:
//   i_clk      base clock
//   i_rst_n    synchronous active-low reset
//   i_ani_stb  one-cycle animation strobe, once per frame
//   i_animate  motion enable; low freezes the paddle
//   i_btn_l    raw left button (asynchronous, active-high)
//   i_btn_r    raw right button (asynchronous, active-high)
//   o_x        paddle left edge (registered)
//   o_dir      motion code: 0 moved right, 1 moved left, 2 still
//   o_x1/o_x2  drawing box x edges: o_x, o_x+WIDTH
//   o_y1/o_y2  drawing box y edges: IY, IY+HEIGHT
//
// Optional feature, macro PADDLE_AI_EN:
//   Adds i_ai_en and i_ball_x. While i_ai_en is high, the paddle tracks the
//   ball instead of following the buttons. The debouncers keep running.
//
// State table:
//   state  | meaning
//   IDLE   | no motion requested, speed held at 1
//   MOVE_L | moving left, ramping speed
//   MOVE_R | moving right, ramping speed

module paddle_ctrl #(
   parameter int          WIDTH       = 100,
   parameter int          HEIGHT      = 10,
   parameter int          IX          = 270,
   parameter int          IY          = 445,
   parameter int          D_WIDTH     = 640,
   parameter int          X_MIN       = 0,
   parameter logic [15:0] DB_CYCLES   = 16'd50000,
   parameter int          RAMP_FRAMES = 8,
   parameter int          MAX_SPEED   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_btn_l,
   input  logic        i_btn_r,
`ifdef PADDLE_AI_EN
   input  logic        i_ai_en,
   input  logic [11:0] i_ball_x,
`endif
   output logic [11:0] o_x,
   output logic [1:0]  o_dir,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2
);

   localparam int SPD_W  = $clog2(MAX_SPEED + 1);
   localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);

   localparam logic [SPD_W-1:0]  SPD_ONE   = SPD_W'(1);
   localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(MAX_SPEED);
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
   localparam logic [12:0]       X_MIN13   = 13'(X_MIN);
   localparam logic [12:0]       X_MAX13   = 13'(D_WIDTH - WIDTH);
   localparam logic [11:0]       X_MIN12   = 12'(X_MIN);
   localparam logic [11:0]       X_MAX12   = 12'(D_WIDTH - WIDTH);

   localparam logic [1:0] REQ_NONE = 2'd0;
   localparam logic [1:0] REQ_L    = 2'd1;
   localparam logic [1:0] REQ_R    = 2'd2;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_STILL = 2'd2;

   typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

   state_t              state;
   logic [SPD_W-1:0]    speed;
   logic [RAMP_W-1:0]   ramp;

   // Bit 1 is the left button and bit 0 is the right button.
   logic [1:0]  sync1, sync2, btn_db;
   logic [15:0] db_cnt [2];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         btn_db    <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= {i_btn_l, i_btn_r};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == btn_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_CYCLES - 16'd1) begin
               btn_db[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   logic [1:0] req;

`ifdef PADDLE_AI_EN
   logic [12:0] centre, ball13;
   assign centre = {1'b0, o_x} + 13'(WIDTH / 2);
   assign ball13 = {1'b0, i_ball_x};
`endif

   always_comb begin
      req = REQ_NONE;
      case (btn_db)
         2'b10:   req = REQ_L;
         2'b01:   req = REQ_R;
         default: req = REQ_NONE;
      endcase
`ifdef PADDLE_AI_EN
      if (i_ai_en) begin
         req = REQ_NONE;
         if (ball13 + 13'd8 < centre)
            req = REQ_L;
         else if (ball13 > centre + 13'd8)
            req = REQ_R;
      end
`endif
   end

   // A fresh move, from IDLE or a reversal, restarts at speed 1 with an empty
   // ramp. The move that starts a run counts toward the ramp, so speed goes up
   // after exactly RAMP_FRAMES moves at each speed.
   logic              entry;
   logic [SPD_W-1:0]  spd_cur;
   logic [RAMP_W-1:0] ramp_cur;
   logic [12:0]       x13, spd13;
   logic [11:0]       x_next;
   logic [1:0]        dir_next;

   always_comb begin
      entry    = (req == REQ_L && state != MOVE_L) ||
                 (req == REQ_R && state != MOVE_R);
      spd_cur  = entry ? SPD_ONE : speed;
      ramp_cur = entry ? '0 : ramp;
      x13      = {1'b0, o_x};
      spd13    = 13'(spd_cur);
      x_next   = o_x;
      if (req == REQ_L)
         x_next = (x13 < X_MIN13 + spd13) ? X_MIN12 : o_x - 12'(spd_cur);
      else if (req == REQ_R)
         x_next = (x13 + spd13 > X_MAX13) ? X_MAX12 : o_x + 12'(spd_cur);
      if (x_next > o_x)
         dir_next = DIR_RIGHT;
      else if (x_next < o_x)
         dir_next = DIR_LEFT;
      else
         dir_next = DIR_STILL;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
         speed <= SPD_ONE;
         ramp  <= '0;
         o_x   <= 12'(IX);
         o_dir <= DIR_STILL;
      end else if (i_ani_stb && i_animate) begin
         o_x   <= x_next;
         o_dir <= dir_next;
         if (req == REQ_NONE) begin
            state <= IDLE;
            speed <= SPD_ONE;
            ramp  <= '0;
         end else begin
            state <= (req == REQ_L) ? MOVE_L : MOVE_R;
            if (ramp_cur == RAMP_LAST) begin
               ramp  <= '0;
               speed <= (spd_cur == SPD_MAX) ? spd_cur : spd_cur + SPD_ONE;
            end else begin
               ramp  <= ramp_cur + RAMP_W'(1);
               speed <= spd_cur;
            end
         end
      end
   end

   assign o_x1 = o_x;
   assign o_x2 = o_x + 12'(WIDTH);
   assign o_y1 = 12'(IY);
   assign o_y2 = 12'(IY + HEIGHT);

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;

   localparam int DB    = 4;
   localparam int RAMP  = 8;
   localparam int MAXS  = 4;
   localparam int XMIN  = 0;
   localparam int XMAX  = 540;
   localparam int IXV   = 270;
   localparam int WID   = 100;
   localparam int IYV   = 445;
   localparam int HGT   = 10;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        ani_stb = 0;
   logic        animate = 1;
   logic        btn_l = 0;
   logic        btn_r = 0;
   logic [11:0] x, x1, x2, y1, y2;
   logic [1:0]  dir;
`ifdef PADDLE_AI_EN
   logic        ai_en = 0;
   logic [11:0] ball_x = 12'd0;
`endif

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   paddle_ctrl #(.DB_CYCLES(16'd4)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_ani_stb (ani_stb),
      .i_animate (animate),
      .i_btn_l   (btn_l),
      .i_btn_r   (btn_r),
`ifdef PADDLE_AI_EN
      .i_ai_en   (ai_en),
      .i_ball_x  (ball_x),
`endif
      .o_x       (x),
      .o_dir     (dir),
      .o_x1      (x1),
      .o_x2      (x2),
      .o_y1      (y1),
      .o_y2      (y2)
   );

   // Behavioural model. A button's debounced level flips once the raw level,
   // seen two samples late through the synchronizer, has disagreed with it
   // for DB consecutive samples. Within a run of moves in one direction, the
   // k-th move (0-based) travels min(MAXS, 1 + k/RAMP) pixels.
   bit hl [DB+1];
   bit hr [DB+1];
   bit m_dl, m_dr;
   int m_x = IXV, m_dir = 2, m_run = 0, m_mv = 0;
   bit chk_en = 0;

   always @(posedge clk) begin
      bit s_stb, s_anim, s_rst, s_l, s_r, flip_l, flip_r;
      s_stb = ani_stb; s_anim = animate; s_rst = rst_n; s_l = btn_l; s_r = btn_r;
      if (!s_rst) begin
         for (int i = 0; i <= DB; i++) begin hl[i] = 0; hr[i] = 0; end
         m_dl = 0; m_dr = 0; m_x = IXV; m_dir = 2; m_run = 0; m_mv = 0;
         chk_en = 1;
      end else begin
         if (s_stb && s_anim) begin
            int req, spd, nx;
            req = (m_dl && !m_dr) ? 1 : (m_dr && !m_dl) ? 2 : 0;
            if (req == 0) begin
               m_mv = 0; m_run = 0; m_dir = 2;
            end else begin
               if (req != m_mv) m_run = 0;
               spd = 1 + m_run / RAMP;
               if (spd > MAXS) spd = MAXS;
               nx = (req == 1) ? m_x - spd : m_x + spd;
               if (nx < XMIN) nx = XMIN;
               if (nx > XMAX) nx = XMAX;
               m_dir = (nx > m_x) ? 0 : (nx < m_x) ? 1 : 2;
               m_x = nx; m_run++; m_mv = req;
            end
         end
         flip_l = 1; flip_r = 1;
         for (int i = 1; i <= DB; i++) begin
            if (hl[i] == m_dl) flip_l = 0;
            if (hr[i] == m_dr) flip_r = 0;
         end
         if (flip_l) m_dl = !m_dl;
         if (flip_r) m_dr = !m_dr;
         for (int i = DB; i >= 1; i--) begin hl[i] = hl[i-1]; hr[i] = hr[i-1]; end
         hl[0] = s_l; hr[0] = s_r;
      end
      #1;
      if (chk_en) begin
         cmp_cnt++;
         if (x !== 12'(m_x) || dir !== 2'(m_dir) || x1 !== 12'(m_x) ||
             x2 !== 12'(m_x + WID) || y1 !== 12'(IYV) || y2 !== 12'(IYV + HGT)) begin
            err_cnt++;
            $display("FAIL model t=%0t: got x=%0d dir=%0d x1=%0d x2=%0d y1=%0d y2=%0d expected x=%0d dir=%0d x2=%0d y1=%0d y2=%0d",
                     $time, x, dir, x1, x2, y1, y2, m_x, m_dir, m_x + WID, IYV, IYV + HGT);
         end
      end
   end

   task automatic lit(input string nm, input int act, input int exp);
      cmp_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input int n);
      repeat (n) begin
         @(negedge clk) ani_stb = 1;
         @(negedge clk) ani_stb = 0;
         tick(2);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 0;
      @(negedge clk) rst_n = 1;
   endtask

   initial begin
      // Reset
      tick(2);
      rst_n = 1;
      tick(1);
      lit("reset_x", x, 270);
      lit("reset_dir", dir, 2);
      lit("reset_x1", x1, 270);
      lit("reset_x2", x2, 370);
      lit("reset_y1", y1, 445);
      lit("reset_y2", y2, 455);

      // Hold-right ramp: 1x8, 2x8, 3x4
      btn_r = 1;
      tick(10);
      strobe(8);
      lit("ramp_8", x, 278);
      strobe(8);
      lit("ramp_16", x, 294);
      strobe(4);
      lit("ramp_20", x, 306);
      lit("ramp_dir", dir, 0);

      // Paused play freezes position
      animate = 0;
      strobe(3);
      lit("pause_x", x, 306);
      animate = 1;

      // Both pressed cancels
      btn_l = 1;
      tick(10);
      strobe(1);
      lit("both_x", x, 306);
      lit("both_dir", dir, 2);

      // Left only, then direct left->right switch
      btn_r = 0;
      tick(10);
      strobe(3);
      lit("left_x", x, 303);
      lit("left_dir", dir, 1);
      @(negedge clk) begin btn_l = 0; btn_r = 1; end
      tick(10);
      strobe(1);
      lit("rev_x", x, 304);
      lit("rev_dir", dir, 0);

      // Reversal to left, then reset mid-move
      btn_r = 0; btn_l = 1;
      tick(10);
      strobe(5);
      lit("left5_x", x, 299);
      @(negedge clk) rst_n = 0;
      @(posedge clk) #1;
      lit("rst_mid_x", x, 270);
      lit("rst_mid_dir", dir, 2);
      @(negedge clk) rst_n = 1;

      // Left clamp: 270 -> 2 after 79 strobes, then pinned at 0
      tick(10);
      strobe(79);
      lit("clamp_pre_x", x, 2);
      strobe(1);
      lit("clamp_x", x, 0);
      lit("clamp_dir", dir, 1);
      strobe(1);
      lit("pinned_x", x, 0);
      lit("pinned_dir", dir, 2);

      // Debounce reject: 3-cycle glitch
      btn_l = 0;
      do_reset();
      tick(10);
      btn_r = 1;
      tick(3);
      btn_r = 0;
      tick(2);
      strobe(10);
      lit("glitch_x", x, 270);
      lit("glitch_dir", dir, 2);

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
